// File: rtl/branch_exec_unit_pkg.sv
// Shared types and constants for the branch execution unit: opcode encodings,
// datapath widths and the resolved-result record carried on the branch CDB.
package branch_exec_unit_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned TAG_W = 4;
    localparam int unsigned OP_W  = 6;

    localparam logic [OP_W-1:0] OP_JAL  = 6'd1;
    localparam logic [OP_W-1:0] OP_JALR = 6'd2;
    localparam logic [OP_W-1:0] OP_BEQ  = 6'd3;
    localparam logic [OP_W-1:0] OP_BNE  = 6'd4;
    localparam logic [OP_W-1:0] OP_BLT  = 6'd5;
    localparam logic [OP_W-1:0] OP_BGE  = 6'd6;
    localparam logic [OP_W-1:0] OP_BLTU = 6'd7;
    localparam logic [OP_W-1:0] OP_BGEU = 6'd8;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  data;
        logic [XLEN-1:0]  target;
        logic             taken;
    } res_t;

endpackage

// File: rtl/branch_exec_unit_if.sv
// Issue port from the branch reservation station plus the branch CDB slot.
// master = RS/CDB arbiter side, slave = branch execution unit.
interface branch_exec_unit_if;
    import branch_exec_unit_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [OP_W-1:0]  in_op;
    logic [XLEN-1:0]  in_reg1;
    logic [XLEN-1:0]  in_reg2;
    logic [XLEN-1:0]  in_imm;
    logic [XLEN-1:0]  in_pc;
    logic [TAG_W-1:0] in_tag;

    logic             cdb_valid;
    logic [TAG_W-1:0] cdb_tag;
    logic [XLEN-1:0]  cdb_data;
    logic [XLEN-1:0]  cdb_target;
    logic             cdb_taken;
    logic             cdb_grant;

    modport master (
        output in_valid, in_op, in_reg1, in_reg2, in_imm, in_pc, in_tag, cdb_grant,
        input  in_ready, cdb_valid, cdb_tag, cdb_data, cdb_target, cdb_taken
    );

    modport slave (
        input  in_valid, in_op, in_reg1, in_reg2, in_imm, in_pc, in_tag, cdb_grant,
        output in_ready, cdb_valid, cdb_tag, cdb_data, cdb_target, cdb_taken
    );

endinterface

// File: rtl/branch_resolve.sv
// Purely combinational branch/jump resolution: direction, next pc and link value.
module branch_resolve
    import branch_exec_unit_pkg::*;
(
    input  logic [OP_W-1:0] op,
    input  logic [XLEN-1:0] reg1,
    input  logic [XLEN-1:0] reg2,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] pc,
    output logic            taken,
    output logic [XLEN-1:0] target,
    output logic [XLEN-1:0] data
);

    logic [XLEN-1:0] link;
    logic [XLEN-1:0] rel_target;
    logic            is_cond;
    logic            cond;

    assign link       = pc + XLEN'(4);
    assign rel_target = pc + imm;

    always_comb begin
        is_cond = 1'b0;
        cond    = 1'b0;
        taken   = 1'b0;
        target  = link;
        data    = '0;
        case (op)
            OP_JAL: begin
                taken  = 1'b1;
                target = rel_target;
                data   = link;
            end
            OP_JALR: begin
                taken  = 1'b1;
                target = (reg1 + imm) & ~XLEN'(1);
                data   = link;
            end
            OP_BEQ:  begin is_cond = 1'b1; cond = (reg1 == reg2);                   end
            OP_BNE:  begin is_cond = 1'b1; cond = (reg1 != reg2);                   end
            OP_BLT:  begin is_cond = 1'b1; cond = ($signed(reg1) <  $signed(reg2)); end
            OP_BGE:  begin is_cond = 1'b1; cond = ($signed(reg1) >= $signed(reg2)); end
            OP_BLTU: begin is_cond = 1'b1; cond = (reg1 <  reg2);                   end
            OP_BGEU: begin is_cond = 1'b1; cond = (reg1 >= reg2);                   end
            default: ;
        endcase
        if (is_cond) begin
            taken  = cond;
            target = cond ? rel_target : link;
        end
    end

endmodule

// File: rtl/branch_exec_unit.sv
// Branch execution unit: resolves issued branches and queues the results in a
// small FIFO until the branch CDB slot is granted; a ROB flush empties the queue.
module branch_exec_unit
    import branch_exec_unit_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic rdy,
    input  logic flush,
    branch_exec_unit_if.slave bus
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    res_t             mem_q [DEPTH];

    res_t            new_res;
    res_t            head;
    logic            res_taken;
    logic [XLEN-1:0] res_target;
    logic [XLEN-1:0] res_data;
    logic            full;
    logic            push;
    logic            pop;

    branch_resolve u_resolve (
        .op     (bus.in_op),
        .reg1   (bus.in_reg1),
        .reg2   (bus.in_reg2),
        .imm    (bus.in_imm),
        .pc     (bus.in_pc),
        .taken  (res_taken),
        .target (res_target),
        .data   (res_data)
    );

    always_comb begin
        new_res        = '0;
        new_res.tag    = bus.in_tag;
        new_res.data   = res_data;
        new_res.target = res_target;
        new_res.taken  = res_taken;
    end

    // Ready looks only at the registered count, so a full FIFO never accepts on its pop cycle.
    assign full          = (count_q == CNT_W'(DEPTH));
    assign bus.in_ready  = rdy && !rst && !flush && !full;
    assign bus.cdb_valid = (count_q != '0) && !rst;
    assign push          = bus.in_valid && bus.in_ready;
    assign pop           = bus.cdb_valid && bus.cdb_grant && rdy && !flush;

    assign head = mem_q[rd_ptr_q];

    always_comb begin
        bus.cdb_tag    = '0;
        bus.cdb_data   = '0;
        bus.cdb_target = '0;
        bus.cdb_taken  = 1'b0;
        if (bus.cdb_valid) begin
            bus.cdb_tag    = head.tag;
            bus.cdb_data   = head.data;
            bus.cdb_target = head.target;
            bus.cdb_taken  = head.taken;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (push && !pop) count_d = count_q + CNT_W'(1);
            if (pop && !push) count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (rdy) begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else if (push) begin
            mem_q[wr_ptr_q] <= new_res;
        end
    end

endmodule

// File: tb/tb_branch_exec_unit.sv
// Self-checking bench for branch_exec_unit: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_branch_exec_unit;
    import branch_exec_unit_pkg::*;

    localparam int unsigned DEPTH = 2;

    logic clk = 1'b0;
    logic rst;
    logic rdy;
    logic flush;

    always #5 clk = ~clk;

    branch_exec_unit_if bus ();

    branch_exec_unit #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .rdy   (rdy),
        .flush (flush),
        .bus   (bus)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    res_t model_q[$];

    function automatic res_t ref_resolve(input logic [OP_W-1:0] op, input logic [31:0] r1,
                                         input logic [31:0] r2, input logic [31:0] imm,
                                         input logic [31:0] pc, input logic [TAG_W-1:0] tag);
        res_t        r;
        logic [31:0] sum;
        bit          cond;
        bit          is_br;
        r        = '0;
        r.tag    = tag;
        r.target = pc + 32'd4;
        cond     = 0;
        is_br    = 1;
        case (op)
            OP_JAL:  begin r.taken = 1; r.target = pc + imm; r.data = pc + 32'd4; is_br = 0; end
            OP_JALR: begin
                sum = r1 + imm;
                r.taken = 1; r.target = {sum[31:1], 1'b0}; r.data = pc + 32'd4; is_br = 0;
            end
            OP_BEQ:  cond = (r1 == r2);
            OP_BNE:  cond = (r1 != r2);
            OP_BLT:  cond = ($signed(r1) < $signed(r2));
            OP_BGE:  cond = !($signed(r1) < $signed(r2));
            OP_BLTU: cond = (r1 < r2);
            OP_BGEU: cond = !(r1 < r2);
            default: is_br = 0;
        endcase
        if (is_br && cond) begin
            r.taken  = 1;
            r.target = pc + imm;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    task automatic check_outputs(input string where);
        res_t h;
        logic v;
        h = '0;
        v = 1'b0;
        if (!rst && model_q.size() != 0) begin
            h = model_q[0];
            v = 1'b1;
        end
        check({where, ".cdb_valid"},  32'(bus.cdb_valid),  32'(v));
        check({where, ".cdb_tag"},    32'(bus.cdb_tag),    32'(h.tag));
        check({where, ".cdb_data"},   bus.cdb_data,        h.data);
        check({where, ".cdb_target"}, bus.cdb_target,      h.target);
        check({where, ".cdb_taken"},  32'(bus.cdb_taken),  32'(h.taken));
    endtask

    // One clock: check ready, advance the model by the edge's rules, check outputs.
    task automatic tick(input string where);
        bit   exp_ready;
        bit   do_push;
        bit   do_pop;
        res_t nr;
        #1;
        exp_ready = rdy && !rst && !flush && (model_q.size() < DEPTH);
        check({where, ".in_ready"}, 32'(bus.in_ready), 32'(exp_ready));
        nr = ref_resolve(bus.in_op, bus.in_reg1, bus.in_reg2, bus.in_imm, bus.in_pc, bus.in_tag);
        do_push = bus.in_valid && exp_ready;
        do_pop  = !rst && rdy && !flush && (model_q.size() != 0) && bus.cdb_grant;
        @(posedge clk);
        #1;
        if (rst) model_q.delete();
        else if (rdy) begin
            if (flush) model_q.delete();
            else begin
                if (do_pop)  void'(model_q.pop_front());
                if (do_push) model_q.push_back(nr);
            end
        end
        check_outputs(where);
    endtask

    task automatic issue(input logic v, input logic [OP_W-1:0] op, input logic [31:0] r1,
                         input logic [31:0] r2, input logic [31:0] imm, input logic [31:0] pc,
                         input logic [TAG_W-1:0] tag);
        bus.in_valid = v;
        bus.in_op    = op;
        bus.in_reg1  = r1;
        bus.in_reg2  = r2;
        bus.in_imm   = imm;
        bus.in_pc    = pc;
        bus.in_tag   = tag;
    endtask

    initial begin
        rst = 1'b1;
        rdy = 1'b1;
        flush = 1'b0;
        bus.cdb_grant = 1'b0;
        issue(1'b0, '0, '0, '0, '0, '0, '0);
        tick("reset0");
        tick("reset1");
        rst = 1'b0;

        // BEQ taken, then popped on the next grant
        bus.cdb_grant = 1'b1;
        issue(1'b1, OP_BEQ, 32'd5, 32'd5, 32'h20, 32'h100, 4'd3);
        tick("beq");
        check("beq.target_const", bus.cdb_target, 32'h120);
        check("beq.tag_const", 32'(bus.cdb_tag), 32'd3);
        issue(1'b1, OP_BLT, 32'hFFFF_FFFF, 32'd1, 32'h40, 32'h300, 4'd4);
        tick("blt");
        check("blt.taken_const", 32'(bus.cdb_taken), 32'd1);
        check("blt.target_const", bus.cdb_target, 32'h340);
        issue(1'b1, OP_BLTU, 32'hFFFF_FFFF, 32'd1, 32'h40, 32'h300, 4'd5);
        tick("bltu");
        check("bltu.taken_const", 32'(bus.cdb_taken), 32'd0);
        check("bltu.target_const", bus.cdb_target, 32'h304);
        issue(1'b1, OP_JALR, 32'h1003, 32'd0, 32'h4, 32'h200, 4'd6);
        tick("jalr");
        check("jalr.target_const", bus.cdb_target, 32'h1006);
        check("jalr.data_const", bus.cdb_data, 32'h204);
        issue(1'b1, OP_JAL, 32'd0, 32'd0, 32'hFFFF_FFFC, 32'h0, 4'd7);
        tick("jal");
        check("jal.target_const", bus.cdb_target, 32'hFFFF_FFFC);
        check("jal.data_const", bus.cdb_data, 32'h4);
        issue(1'b0, '0, '0, '0, '0, '0, '0);
        tick("drain");
        check("drain.valid_const", 32'(bus.cdb_valid), 32'd0);

        // Backpressure: three issues with no grant, then drain in order
        bus.cdb_grant = 1'b0;
        issue(1'b1, OP_BNE, 32'd1, 32'd2, 32'h10, 32'h400, 4'd1);
        tick("bp1");
        issue(1'b1, OP_BGE, 32'd1, 32'd2, 32'h10, 32'h500, 4'd2);
        tick("bp2");
        issue(1'b1, OP_BGEU, 32'd9, 32'd2, 32'h10, 32'h600, 4'd3);
        tick("bp3_full");
        check("bp3.in_ready_const", 32'(bus.in_ready), 32'd0);
        check("bp3.head_tag_const", 32'(bus.cdb_tag), 32'd1);
        bus.cdb_grant = 1'b1;
        tick("bp4");
        check("bp4.head_tag_const", 32'(bus.cdb_tag), 32'd2);
        tick("bp5");
        check("bp5.head_tag_const", 32'(bus.cdb_tag), 32'd3);
        issue(1'b0, '0, '0, '0, '0, '0, '0);
        tick("bp6");

        // Flush with two entries queued and an issue in the same cycle
        bus.cdb_grant = 1'b0;
        issue(1'b1, OP_JAL, 32'd0, 32'd0, 32'h8, 32'h700, 4'd8);
        tick("fl_fill1");
        issue(1'b1, OP_JAL, 32'd0, 32'd0, 32'h8, 32'h704, 4'd9);
        tick("fl_fill2");
        flush = 1'b1;
        issue(1'b1, OP_JAL, 32'd0, 32'd0, 32'h8, 32'h708, 4'd10);
        tick("flush");
        check("flush.valid_const", 32'(bus.cdb_valid), 32'd0);
        flush = 1'b0;
        issue(1'b0, '0, '0, '0, '0, '0, '0);
        tick("post_flush");
        check("post_flush.in_ready_const", 32'(bus.in_ready), 32'd1);

        // rdy low holds a queued entry even with grant
        issue(1'b1, OP_BEQ, 32'd1, 32'd2, 32'h8, 32'h800, 4'd11);
        tick("hold_fill");
        issue(1'b0, '0, '0, '0, '0, '0, '0);
        bus.cdb_grant = 1'b1;
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) tick("hold");
        check("hold.tag_const", 32'(bus.cdb_tag), 32'd11);
        rdy = 1'b1;
        tick("hold_release");

        // Reset mid-stream
        bus.cdb_grant = 1'b0;
        issue(1'b1, OP_JAL, 32'd0, 32'd0, 32'h8, 32'h900, 4'd12);
        tick("rst_fill");
        rst = 1'b1;
        tick("rst_mid");
        check("rst_mid.valid_const", 32'(bus.cdb_valid), 32'd0);
        rst = 1'b0;

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [31:0] r1;
            r1  = $urandom;
            rst = ($urandom_range(0, 99) == 0);
            rdy = ($urandom_range(0, 7) != 0);
            flush = ($urandom_range(0, 19) == 0);
            bus.cdb_grant = $urandom_range(0, 1) != 0;
            issue($urandom_range(0, 3) != 0, 6'($urandom_range(0, 9)), r1,
                  ($urandom_range(0, 2) == 0) ? r1 : 32'($urandom), 32'($urandom),
                  32'($urandom), 4'($urandom_range(0, 15)));
            tick("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_exec_unit.md
Name: branch_exec_unit

Overview:
- Execution end of the branch reservation-station issue interface.
- Accepts one ready branch/jump per cycle: op, two operand values, immediate, pc, destination ROB tag.
- Resolves direction, target and link value, then buffers results in a small FIFO until granted the branch CDB slot.
- Results go to the ROB and all reservation stations; a ROB flush clears all in-flight state.

Parameters:
XLEN, 32, data/address width
TAG_W, 4, ROB tag width
OP_W, 6, opcode field width
DEPTH, 2, result FIFO entries (power of 2, >=2)

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
rdy  in  1  global enable; 0 freezes all state
flush  in  1  ROB mispredict flush; clears unit
in_valid  in  1  issue request from branch RS
in_ready  out  1  unit can accept this cycle
in_op  in  OP_W  branch opcode
in_reg1  in  XLEN  rs1 value
in_reg2  in  XLEN  rs2 value
in_imm  in  XLEN  sign-extended immediate
in_pc  in  XLEN  instruction pc
in_tag  in  TAG_W  destination ROB tag
cdb_valid  out  1  result at FIFO head
cdb_tag  out  TAG_W  ROB tag of result
cdb_data  out  XLEN  link value (pc+4) or 0
cdb_target  out  XLEN  resolved next pc
cdb_taken  out  1  resolved direction
cdb_grant  in  1  CDB slot granted; pops head when cdb_valid

Behaviour:
- Reset: count=0, pointers=0, all FIFO fields 0. Outputs: cdb_valid=0, cdb_tag=0, cdb_data=0, cdb_target=0, cdb_taken=0, in_ready=0 during rst.
- Priority per edge: rst > !rdy (hold everything) > flush > push/pop.
- in_ready = rdy && !rst && !flush && (count < DEPTH).
  - Registered count only; no combinational path from cdb_grant.
  - A full FIFO does not accept in the same cycle it pops.
- Push happens when in_valid && in_ready. The result is computed combinationally from the inputs and written at the tail on that edge.
- Latency: accept at edge N -> cdb_valid=1 from edge N through the pop edge.
- cdb_* is driven from the head entry. cdb_valid = (count != 0). Outputs are 0 when empty.
- Pop happens when cdb_valid && cdb_grant && rdy. The head advances and the next entry appears on the following cycle.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH.
- flush: count<=0, pointers<=0. Any in_valid that cycle is dropped and no pop occurs. cdb_valid=0 on the next cycle.
- rdy=0: no push, no pop, state held. cdb_* remains visible but cdb_grant is ignored.
- Result rules (32-bit wrap arithmetic):
  - JAL: taken=1, target=pc+imm, data=pc+4.
  - JALR: taken=1, target=(reg1+imm)&~1, data=pc+4.
  - BEQ/BNE: taken = reg1==reg2 / reg1!=reg2.
  - BLT/BGE: signed compare.
  - BLTU/BGEU: unsigned compare.
  - All conditional branches: target = taken ? pc+imm : pc+4, data=0.
  - Any other opcode: taken=0, target=pc+4, data=0.
- A tag is always carried unchanged. The unit never drops an accepted entry except on flush or rst.

Decomposition:
- Shared package holds:
  - OP_JAL, OP_JALR, OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU encodings.
  - XLEN/TAG_W/OP_W constants.
  - Result struct {tag, data, target, taken}.
- One sub-module, branch_resolve: purely combinational op/operand -> {taken, target, data}. The top holds the FIFO and handshake.

Test Plan:
- BEQ, reg1=reg2=5, pc=0x100, imm=0x20, tag=3, grant=1 -> next cycle cdb_valid=1, tag=3, taken=1, target=0x120, data=0. Popped after one cycle.
- BLT reg1=0xFFFFFFFF, reg2=1 -> taken=1. Same operands on BLTU -> taken=0, target=pc+4.
- JALR reg1=0x1003, imm=0x4, pc=0x200 -> target=0x1006, data=0x204, taken=1. JAL pc=0x0 imm=0xFFFFFFFC -> target=0xFFFFFFFC.
- cdb_grant=0, three back-to-back issues (tags 1,2,3) -> tags 1,2 accepted, in_ready=0 while count=2. Raise grant -> tag 1 then tag 2 output in order. Tag 3 is accepted when count<2, then output.
- FIFO holding 2 entries, flush with in_valid=1 -> next cycle cdb_valid=0, count=0. The flush-cycle issue is lost and in_ready returns to 1.
- rdy=0 for 3 cycles with 1 entry and grant=1 -> entry held, no pop. rst asserted mid-stream -> all outputs 0 on the next cycle.
